// File: rtl/cache_write_buffer.sv
// cache_write_buffer: write-back FIFO draining dirty evictions to memory, with youngest-match forwarding lookup.
// Optional macro WB_COALESCE_EN merges a push into an already-queued entry with the same address.
module cache_write_buffer #(
  parameter int DATAWIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNTW = $clog2(DEPTH+1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push,
  input  logic [DATAWIDTH-1:0] push_addr,
  input  logic [DATAWIDTH-1:0] push_data,
  output logic                 full,
  output logic                 empty,
  output logic [CNTW-1:0]      count,
  output logic                 overflow,
  input  logic [DATAWIDTH-1:0] lookup_addr,
  output logic                 lookup_hit,
  output logic [DATAWIDTH-1:0] lookup_data,
  output logic                 mem_write,
  output logic [DATAWIDTH-1:0] mem_addr,
  output logic [DATAWIDTH-1:0] mem_data,
  input  logic                 mem_ack
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic {IDLE, WRITE} state_t;
  state_t r_state, w_next;
  logic [DEPTH-1:0] r_valid;
  logic [DATAWIDTH-1:0] r_addr [DEPTH];
  logic [DATAWIDTH-1:0] r_data [DEPTH];
  logic [PW-1:0] r_head, r_tail;
  logic [CNTW-1:0] r_count;
  logic r_overflow;
  logic [DATAWIDTH-1:0] r_mem_addr, r_mem_data;
  logic w_pop, w_latch, w_coal, w_alloc, w_drop;
  logic [PW-1:0] w_cidx;
  logic [DATAWIDTH-1:0] w_head_data;

  assign full = r_count == CNTW'(DEPTH);
  assign empty = r_count == '0;
  assign count = r_count;
  assign overflow = r_overflow;
  assign mem_write = r_state == WRITE;
  assign mem_addr = r_mem_addr;
  assign mem_data = r_mem_data;
  assign w_pop = (r_state == WRITE) && mem_ack;
  assign w_latch = (r_state == IDLE) && !empty;
  assign w_alloc = push && !full && !w_coal;
  assign w_drop = push && full && !w_coal;

  always_comb begin
    lookup_hit = 1'b0;
    lookup_data = '0;
    for (int i = 0; i < DEPTH; i++)
      if (r_valid[r_head + PW'(i)] && r_addr[r_head + PW'(i)] == lookup_addr) begin
        lookup_hit = 1'b1;
        lookup_data = r_data[r_head + PW'(i)];
      end
  end

`ifdef WB_COALESCE_EN
  always_comb begin
    w_coal = 1'b0;
    w_cidx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (r_valid[r_head + PW'(i)] && r_addr[r_head + PW'(i)] == push_addr &&
          !(r_state == WRITE && r_head + PW'(i) == r_head)) begin
        w_coal = push;
        w_cidx = r_head + PW'(i);
      end
  end
  // a merge into the head on the latching edge must reach memory, not be lost
  assign w_head_data = (w_coal && w_cidx == r_head) ? push_data : r_data[r_head];
`else
  assign w_coal = 1'b0;
  assign w_cidx = '0;
  assign w_head_data = r_data[r_head];
`endif

  always_ff @(posedge clock) begin
    if (w_alloc) begin
      r_addr[r_tail] <= push_addr;
      r_data[r_tail] <= push_data;
    end
    if (w_coal) r_data[w_cidx] <= push_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head <= r_head + PW'(1);
      end
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_tail <= r_tail + PW'(1);
      end
      if (w_drop) r_overflow <= 1'b1;
      r_count <= r_count + CNTW'(w_alloc) - CNTW'(w_pop);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mem_addr <= '0;
      r_mem_data <= '0;
    end else if (w_latch) begin
      r_mem_addr <= r_addr[r_head];
      r_mem_data <= w_head_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (empty ? IDLE : WRITE) : (mem_ack ? IDLE : WRITE);
  end
endmodule

// File: tb/tb_cache_write_buffer.sv
// tb_cache_write_buffer: directed stimulus with a write scoreboard checked by a negedge memory monitor.
module tb_cache_write_buffer;
  logic clock, reset, push, mem_ack;
  logic [31:0] push_addr, push_data, lookup_addr;
  logic full, empty, overflow, lookup_hit, mem_write;
  logic [2:0] count;
  logic [31:0] lookup_data, mem_addr, mem_data;
  logic [63:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  cache_write_buffer dut (
    .clock(clock), .reset(reset), .push(push), .push_addr(push_addr), .push_data(push_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    logic [63:0] e;
    if (!reset && mem_write && mem_ack) begin
      if (exp_q.size() == 0) chk("unexpected_write", mem_addr, 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        chk("wr_addr", mem_addr, e[63:32]);
        chk("wr_data", mem_data, e[31:0]);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_entry(input logic [31:0] a, input logic [31:0] d, input bit expect_write);
    push = 1'b1;
    push_addr = a;
    push_data = d;
    step();
    push = 1'b0;
    if (expect_write) exp_q.push_back({a, d});
  endtask

  task automatic drain();
    int n = 0;
    mem_ack = 1'b1;
    while (!(empty && !mem_write) && n < 40) begin
      step();
      n++;
    end
    chk("drain_done", {31'd0, empty && !mem_write}, 32'd1);
    mem_ack = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    push = 1'b0;
    push_addr = '0;
    push_data = '0;
    lookup_addr = 32'h100;
    mem_ack = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk("reset_empty", {31'd0, empty}, 32'd1);
    chk("reset_full", {31'd0, full}, 32'd0);
    chk("reset_count", {29'd0, count}, 32'd0);
    chk("reset_mem_write", {31'd0, mem_write}, 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_hit", {31'd0, lookup_hit}, 32'd0);

    push_entry(32'h100, 32'hAAAA, 1);
    chk("t1_count", {29'd0, count}, 32'd1);
    chk("t1_wait_latch", {31'd0, mem_write}, 32'd0);
    chk("t1_hit", {31'd0, lookup_hit}, 32'd1);
    chk("t1_lookup_data", lookup_data, 32'hAAAA);
    step();
    chk("t1_mem_write", {31'd0, mem_write}, 32'd1);
    chk("t1_mem_addr", mem_addr, 32'h100);
    chk("t1_mem_data", mem_data, 32'hAAAA);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("t1_pop_count", {29'd0, count}, 32'd0);
    chk("t1_pop_empty", {31'd0, empty}, 32'd1);
    chk("t1_pop_mem_write", {31'd0, mem_write}, 32'd0);

    for (int i = 0; i < 4; i++) push_entry(32'h300 + i, 32'h10 + i, 1);
    chk("t2_full", {31'd0, full}, 32'd1);
    chk("t2_count", {29'd0, count}, 32'd4);
    push_entry(32'h500, 32'h55, 0);
    chk("t2_overflow", {31'd0, overflow}, 32'd1);
    chk("t2_count_after_drop", {29'd0, count}, 32'd4);
    mem_ack = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("t2_gap_mem_write", {31'd0, mem_write}, {31'd0, k % 2 == 0 && k < 8});
      chk("t2_gap_count", {29'd0, count}, 32'(4 - (k + 1) / 2));
    end
    mem_ack = 1'b0;
    chk("t2_overflow_sticky", {31'd0, overflow}, 32'd1);

    do_reset();
`ifdef WB_COALESCE_EN
    push_entry(32'h200, 32'd1, 0);
    push_entry(32'h200, 32'd2, 1);
    chk("t3_count", {29'd0, count}, 32'd1);
`else
    push_entry(32'h200, 32'd1, 1);
    push_entry(32'h200, 32'd2, 1);
    chk("t3_count", {29'd0, count}, 32'd2);
`endif
    lookup_addr = 32'h200;
    #1;
    chk("t3_hit", {31'd0, lookup_hit}, 32'd1);
    chk("t3_youngest", lookup_data, 32'd2);
    lookup_addr = 32'h204;
    #1;
    chk("t3_miss_hit", {31'd0, lookup_hit}, 32'd0);
    chk("t3_miss_data", lookup_data, 32'd0);
    drain();
    lookup_addr = 32'h200;
    #1;
    chk("t3_drained_hit", {31'd0, lookup_hit}, 32'd0);

    for (int i = 0; i < 4; i++) push_entry(32'h600 + i, 32'h20 + i, 1);
    chk("t4_in_write", {31'd0, mem_write}, 32'd1);
    mem_ack = 1'b1;
    push_entry(32'h700, 32'h77, 0);
    mem_ack = 1'b0;
    chk("t4_overflow", {31'd0, overflow}, 32'd1);
    chk("t4_count", {29'd0, count}, 32'd3);
    chk("t4_full", {31'd0, full}, 32'd0);
    drain();

    do_reset();
    push_entry(32'h800, 32'h55, 0);
    step();
    chk("t5_in_write", {31'd0, mem_write}, 32'd1);
    lookup_addr = 32'h800;
    reset = 1'b1;
    #1;
    chk("t5_async_mem_write", {31'd0, mem_write}, 32'd0);
    chk("t5_async_mem_addr", mem_addr, 32'd0);
    chk("t5_async_mem_data", mem_data, 32'd0);
    chk("t5_async_hit", {31'd0, lookup_hit}, 32'd0);
    chk("t5_async_empty", {31'd0, empty}, 32'd1);
    step();
    reset = 1'b0;
    step();
    chk("t5_count", {29'd0, count}, 32'd0);
    chk("t5_empty", {31'd0, empty}, 32'd1);
    chk("t5_hit", {31'd0, lookup_hit}, 32'd0);

    for (int i = 0; i < 3; i++) push_entry(32'h900 + i, 32'h90 + i, 1);
    drain();
    for (int i = 3; i < 7; i++) push_entry(32'h900 + i, 32'h90 + i, 1);
    chk("t6_full", {31'd0, full}, 32'd1);
    lookup_addr = 32'h905;
    #1;
    chk("t6_wrap_lookup", lookup_data, 32'h95);
    drain();
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
